vscale_dmem_responder: RTL and testbench

VSCALE_DMEM_RESPONDER -- requirements
Module: vscale_dmem_responder

---
 rtl/vscale_dmem_responder_pkg.sv | 15 +
 rtl/vscale_dmem_bytemask.sv | 20 ++
 rtl/vscale_dmem_responder.sv | 91 +++++++++
 tb/tb_vscale_dmem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vscale_dmem_responder_pkg.sv
// vscale_dmem_responder_pkg: shared memory-access size encodings and responder FSM states.
package vscale_dmem_responder_pkg;

    localparam int MEM_TYPE_WIDTH = 2;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB = 2'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH = 2'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STALL,
        ST_RESP
    } dmem_state_e;

endpackage

// File: rtl/vscale_dmem_bytemask.sv
// vscale_dmem_bytemask: access size and low address bits to byte-lane enables plus a misalignment flag.
module vscale_dmem_bytemask
    import vscale_dmem_responder_pkg::*;
(
    input  logic [MEM_TYPE_WIDTH-1:0] size_i,
    input  logic [1:0]                addr_i,
    output logic [3:0]                be_o,
    output logic                      misalign_o
);

    assign be_o = (size_i == MEM_TYPE_SB) ? 4'b0001 << addr_i :
                  (size_i == MEM_TYPE_SH) ? 4'b0011 << {addr_i[1], 1'b0} :
                  (size_i == MEM_TYPE_SW) ? 4'b1111 : 4'b0000;

    // Unknown size encodings are reported through the same flag as misalignment.
    assign misalign_o = (size_i == MEM_TYPE_SH) ? addr_i[0] :
                        (size_i == MEM_TYPE_SW) ? (addr_i != 2'b00) :
                        (size_i != MEM_TYPE_SB);

endmodule

// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: word-array data memory answering the vscale two-phase dmem interface
// with optional fixed stall cycles per request.
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [31:0]               dmem_addr,
    input  logic [31:0]               dmem_wdata_delayed,
    output logic [31:0]               dmem_rdata,
    output logic                      dmem_wait,
    output logic                      dmem_badmem_e
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH);
    localparam logic [3:0]  WAITS = 4'(WAIT_CYCLES);

    dmem_state_e               state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [31:0]               addr_q;
    logic                      wen_q;
    logic [MEM_TYPE_WIDTH-1:0] size_q;
    logic [31:0]               mem [DEPTH];
    logic [32:0]               diff;
    logic [AW-1:0]             idx;
    logic [3:0]                be;
    logic                      misalign, err, accept, resp;

    vscale_dmem_bytemask u_mask (
        .size_i    (size_q),
        .addr_i    (addr_q[1:0]),
        .be_o      (be),
        .misalign_o(misalign)
    );

    // An address below BASE_ADDR underflows into bit 32 and so also fails the limit test.
    assign diff          = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign idx           = diff[AW+1:2];
    assign err           = misalign || (diff >= LIMIT);
    assign resp          = (state_q == ST_RESP);
    assign accept        = dmem_en && !dmem_wait;
    assign dmem_wait     = (state_q == ST_STALL);
    assign dmem_badmem_e = resp && err;
    assign dmem_rdata    = (resp && !err) ? mem[idx] : 32'h0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_STALL) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ST_RESP : ST_STALL;
        end else begin
            cnt_d   = accept ? WAITS : 4'd0;
            state_d = !accept ? ST_IDLE : (WAITS == 4'd0) ? ST_RESP : ST_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= dmem_addr;
                wen_q  <= dmem_wen;
                size_q <= dmem_size;
            end
        end
    end

    // Stores land on the edge that ends RESP; a reset beforehand leaves the array untouched.
    always_ff @(posedge clk) begin
        if (resp && wen_q && !err)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= dmem_wdata_delayed[8*b +: 8];
    end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// tb_vscale_dmem_responder: three responders (WAIT_CYCLES 0, 2, 3) checked against a byte-level memory model.
module tb_vscale_dmem_responder;

    localparam logic [31:0] MEM_BYTES = 32'h400;
    localparam int WC [3] = '{0, 2, 3};

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          crd;
        bit          bd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        en [3];
    logic        wen [3];
    logic [1:0]  size [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        wt [3];
    logic        bad [3];

    logic [31:0] mdl [3][256];
    int n_cmp = 0;
    int n_bad = 0;

    vscale_dmem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst_n[0]), .dmem_en(en[0]), .dmem_wen(wen[0]), .dmem_size(size[0]),
        .dmem_addr(addr[0]), .dmem_wdata_delayed(wdata[0]), .dmem_rdata(rdata[0]),
        .dmem_wait(wt[0]), .dmem_badmem_e(bad[0]));
    vscale_dmem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .reset(rst_n[1]), .dmem_en(en[1]), .dmem_wen(wen[1]), .dmem_size(size[1]),
        .dmem_addr(addr[1]), .dmem_wdata_delayed(wdata[1]), .dmem_rdata(rdata[1]),
        .dmem_wait(wt[1]), .dmem_badmem_e(bad[1]));
    vscale_dmem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .reset(rst_n[2]), .dmem_en(en[2]), .dmem_wen(wen[2]), .dmem_size(size[2]),
        .dmem_addr(addr[2]), .dmem_wdata_delayed(wdata[2]), .dmem_rdata(rdata[2]),
        .dmem_wait(wt[2]), .dmem_badmem_e(bad[2]));

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (a >= MEM_BYTES) || (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    // Replicated store data: byte n of the access comes from lane (a%4)+n of wd.
    function automatic void ref_store(input int k, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int lane = int'(a % 4);
        for (int i = 0; i < (1 << sz); i++)
            mdl[k][a[9:2]][8*(lane+i) +: 8] = wd[8*(lane+i) +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int k, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit bd, output int nw);
        en[k] = 1'b1; wen[k] = w; size[k] = sz; addr[k] = a;
        step();
        en[k] = 1'b0; wdata[k] = wd; nw = 0;
        while (wt[k] === 1'b1 && nw < 40) begin
            nw++;
            step();
        end
        rd = rdata[k];
        bd = bad[k];
        step();
    endtask

    task automatic check_op(input int k, input bit w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input string nm);
        logic [31:0] rd, exp_rd;
        bit bd, e;
        int nw;
        e = ref_err(sz, a);
        exp_rd = e ? 32'h0 : mdl[k][a[9:2]];
        txn(k, w, sz, a, wd, rd, bd, nw);
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " badmem"}, 32'(bd), 32'(e));
        chk({nm, " waits"}, 32'(nw), 32'(WC[k]));
        if (w && !e) ref_store(k, sz, a, wd);
    endtask

    initial begin
        vec_t tbl [16];
        logic [31:0] rd, d, a, old;
        bit bd, w;
        int nw;
        logic [1:0] sz;

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b1; en[k] = 1'b0; wen[k] = 1'b0; size[k] = 2'd0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async reset wait %0d", k), 32'(wt[k]), 32'h0);
            chk($sformatf("async reset rdata %0d", k), rdata[k], 32'h0);
            chk($sformatf("async reset badmem %0d", k), 32'(bad[k]), 32'h0);
        end
        #19;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        step();
        for (int k = 0; k < 3; k++) chk($sformatf("idle wait %0d", k), 32'(wt[k]), 32'h0);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++) begin
                d = $urandom;
                txn(k, 1'b1, 2'd2, 32'(i * 4), d, rd, bd, nw);
                mdl[k][i] = d;
            end

        tbl[0]  = '{1'b1, 2'd2, 32'h010, 32'h11223344, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 32'h013, 32'hAAAAAAAA, 32'h11223344, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 2'd2, 32'h010, 32'h0,        32'hAA223344, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 32'h012, 32'h55665566, 32'hAA223344, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'd2, 32'h010, 32'h0,        32'h55663344, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 32'h011, 32'h77777777, 32'h55663344, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 32'h010, 32'h0,        32'h55667744, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'd2, 32'h020, 32'h01020304, 32'h0,        1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'd1, 32'h021, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b1};
        tbl[9]  = '{1'b0, 2'd2, 32'h020, 32'h0,        32'h01020304, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 2'd2, 32'h400, 32'h12345678, 32'h0,        1'b1, 1'b1};
        tbl[11] = '{1'b1, 2'd2, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd2, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 2'd2, 32'h3FE, 32'h0,        32'h0,        1'b1, 1'b1};
        tbl[14] = '{1'b0, 2'd3, 32'h010, 32'h0,        32'h0,        1'b1, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 32'hFFFFFFFF, 32'h0,   32'h0,        1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            txn(0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, rd, bd, nw);
            if (tbl[i].crd) chk($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d badmem", i), 32'(bd), 32'(tbl[i].bd));
            chk($sformatf("vec%0d waits", i), 32'(nw), 32'h0);
            if (tbl[i].w && !tbl[i].bd) ref_store(0, tbl[i].sz, tbl[i].a, tbl[i].wd);
        end

        // Back-to-back store then load of the same word with no stalls.
        en[0] = 1'b1; wen[0] = 1'b1; size[0] = 2'd2; addr[0] = 32'h10;
        step();
        chk("b2b store wait", 32'(wt[0]), 32'h0);
        wen[0] = 1'b0; wdata[0] = 32'hDEADBEEF;
        step();
        chk("b2b load wait", 32'(wt[0]), 32'h0);
        chk("b2b load rdata", rdata[0], 32'hDEADBEEF);
        en[0] = 1'b0;
        step();
        chk("b2b idle rdata", rdata[0], 32'h0);
        mdl[0][4] = 32'hDEADBEEF;

        // Two stalls per request; a held request is re-accepted only in RESP.
        en[1] = 1'b1; wen[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h40;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("stall2 c%0d wait", c), 32'(wt[1]), (c % 3 != 2) ? 32'h1 : 32'h0);
            chk($sformatf("stall2 c%0d rdata", c), rdata[1], (c % 3 == 2) ? mdl[1][16] : 32'h0);
            if (c == 3) en[1] = 1'b0;
        end
        step();
        chk("stall2 idle wait", 32'(wt[1]), 32'h0);

        // Reset during the second stall cycle of a store aborts it.
        old = mdl[2][32];
        en[2] = 1'b1; wen[2] = 1'b1; size[2] = 2'd2; addr[2] = 32'h80;
        step();
        en[2] = 1'b0; wdata[2] = ~old;
        step();
        chk("abort stall wait", 32'(wt[2]), 32'h1);
        #2 rst_n[2] = 1'b0;
        #1;
        chk("abort reset wait", 32'(wt[2]), 32'h0);
        chk("abort reset rdata", rdata[2], 32'h0);
        chk("abort reset badmem", 32'(bad[2]), 32'h0);
        step();
        step();
        #3 rst_n[2] = 1'b1;
        step();
        check_op(2, 1'b0, 2'd2, 32'h80, 32'h0, "abort reload");

        for (int n = 0; n < 300; n++) begin
            int k = $urandom_range(0, 2);
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) != 0 && sz != 2'd0) a[1:0] = (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
            if ($urandom_range(0, 7) == 0) a = a + MEM_BYTES * 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = 32'hFFFFFF00 | a;
            check_op(k, w, sz, a, $urandom, $sformatf("rnd%0d k%0d", n, k));
        end

        for (int i = 0; i < 256; i++)
            check_op(0, 1'b0, 2'd2, 32'(i * 4), 32'h0, $sformatf("sweep w%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
